// File: rtl/execute_pkg.sv
`default_nettype none
// ============================================================================
// Module  : execute_pkg
// Purpose : Shared opcode encodings and FSM state type for the execute /
//           writeback stage.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package execute_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/execute_writeback_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : shift_add_multiplier
// Purpose : Unsigned iterative shift-add multiplier, one partial product per
//           cycle, DATA_WIDTH iterations in total.
// Ports   : clk, rst_n    - clock, async active-low reset
//           start         - load a/b (single-cycle pulse)
//           a, b          - multiplicand, multiplier
//           busy          - iterations still in flight
//           done          - one-cycle pulse, product final
//           product       - 2*DATA_WIDTH accumulator
// Revision: 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic                    busy,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] product
);

    localparam int            CW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic [2*DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0]   mplier;
    logic [CW-1:0]           count;
    logic                    running;

    assign busy = running;

    // Iteration 0 is folded into the load so that the final product is ready
    // DATA_WIDTH-1 edges after start; the parent can then leave its compute
    // state exactly DATA_WIDTH edges after the start edge. count holds the
    // index of the iteration just completed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                product <= b[0] ? {{DATA_WIDTH{1'b0}}, a} : '0;
                mcand   <= {{DATA_WIDTH{1'b0}}, a} << 1;
                mplier  <= b >> 1;
                count   <= '0;
                running <= (DATA_WIDTH > 1);
                done    <= (DATA_WIDTH == 1);
            end else if (running) begin
                if (mplier[0]) begin
                    product <= product + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
                if (count == LAST - 1'b1) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/execute_writeback.sv
`default_nettype none
// ============================================================================
// Module  : execute_writeback
// Purpose : Executes one decoded operation (ADD/SUB/AND in one cycle, MUL
//           iteratively) and writes the result to data memory, then pulses
//           done.
// Ports   : clk, rst_n              - clock, async active-low reset
//           valid_in                - level; rising edge starts an operation
//           opcode_in, src1, src2   - operation and operands
//           dst_in                  - destination word address
//           mem_we/mem_addr/mem_wdata - single data-memory write port
//           flag                    - carry/borrow/overflow of last result
//           busy, done              - status; done pulses after the write
//           drop_err                - sticky, start seen while busy
// Revision: 1.0 - initial release
// ============================================================================
import execute_pkg::*;

module execute_writeback #(
    parameter  int DATA_WIDTH       = 8,
    parameter  int DATA_MEMORY_SIZE = 64,
    localparam int ADDR_WIDTH       = $clog2(DATA_MEMORY_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [1:0]            opcode_in,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic [DATA_WIDTH-1:0] src2,
    input  logic [ADDR_WIDTH-1:0] dst_in,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  flag,
    output logic                  busy,
    output logic                  done,
    output logic                  drop_err
);

    state_t                  state, next_state;
    logic                    valid_d;
    logic                    start_pulse;
    logic                    accept;
    logic [1:0]              op_q;
    logic [DATA_WIDTH-1:0]   a_q, b_q;
    logic [ADDR_WIDTH-1:0]   dst_q;

    logic                    mul_start, mul_busy, mul_done;
    logic [2*DATA_WIDTH-1:0] mul_product;

    logic [DATA_WIDTH:0]     sum, diff;
    logic [DATA_WIDTH-1:0]   alu_result;
    logic                    alu_flag;
    logic                    result_ready;

    assign start_pulse = valid_in & ~valid_d;
    assign accept      = start_pulse && (state == IDLE) && !mul_busy;

    // The multiplier loads straight from the input ports on the accept edge,
    // in parallel with the operand latches, so no cycle is lost.
    assign mul_start   = accept && (opcode_in == OP_MUL);

    assign result_ready = (state == CALC) && ((op_q != OP_MUL) || mul_done);

    shift_add_multiplier #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (src1),
        .b       (src2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Extra top bit carries out the ADD carry and the SUB borrow.
    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        alu_result = '0;
        alu_flag   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_result = sum[DATA_WIDTH-1:0];
                alu_flag   = sum[DATA_WIDTH];
            end
            OP_SUB: begin
                alu_result = diff[DATA_WIDTH-1:0];
                alu_flag   = diff[DATA_WIDTH];
            end
            OP_MUL: begin
                alu_result = mul_product[DATA_WIDTH-1:0];
                alu_flag   = |mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            default: begin
                alu_result = a_q & b_q;
                alu_flag   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        mem_we     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (result_ready) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                busy       = 1'b1;
                mem_we     = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d   <= 1'b0;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            dst_q     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            flag      <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            valid_d <= valid_in;
            if (accept) begin
                op_q  <= opcode_in;
                a_q   <= src1;
                b_q   <= src2;
                dst_q <= dst_in;
            end
            // Address/data/flag are captured only when a result is final and
            // then hold until the next one; mem_we alone qualifies them.
            if (result_ready) begin
                mem_addr  <= dst_q;
                mem_wdata <= alu_result;
                flag      <= alu_flag;
            end
            if (start_pulse && !accept) begin
                drop_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
